// File: rtl/layer_seq_pkg.sv
// Shared types and default widths for the MLP layer sequencer.
package layer_seq_pkg;

  localparam int IN_W    = 16;  // input count / input index width
  localparam int NEU_W   = 8;   // neuron count / neuron index width
  localparam int WADDR_W = 24;  // flat weight address width (>= IN_W + NEU_W)

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_MAC   = 3'd3,
    S_ACT   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/layer_sequencer_if.sv
// Control bundle between the network controller / neuron datapath and the
// layer sequencer. The sequencer uses the slave side.
interface layer_sequencer_if #(
  parameter int IN_W    = layer_seq_pkg::IN_W,
  parameter int NEU_W   = layer_seq_pkg::NEU_W,
  parameter int WADDR_W = layer_seq_pkg::WADDR_W
);

  // Layer request from the network controller
  logic               start;
  logic [IN_W-1:0]    n_inputs;
  logic [NEU_W-1:0]   n_neurons;
  logic               ready;
  logic               done;

  // Datapath enables and memory addresses
  logic               acc_clear;
  logic               load_input;
  logic               acc_en;
  logic               act_en;
  logic               out_we;
  logic [IN_W-1:0]    input_addr;
  logic [WADDR_W-1:0] weight_addr;
  logic [NEU_W-1:0]   out_addr;

  modport master (
    output start, n_inputs, n_neurons,
    input  ready, done, acc_clear, load_input, acc_en, act_en, out_we,
    input  input_addr, weight_addr, out_addr
  );

  modport slave (
    input  start, n_inputs, n_neurons,
    output ready, done, acc_clear, load_input, acc_en, act_en, out_we,
    output input_addr, weight_addr, out_addr
  );

endinterface

// File: rtl/layer_seq_counter.sv
// Index counter with clear, increment and a terminal flag that is high when
// the count equals limit-1 (compared at full width).
module layer_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,    // synchronous, active-low
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: clear has priority over increment
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all flops update together from pre-edge values.
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == limit - W'(1));

endmodule

// File: rtl/layer_sequencer.sv
// Walks neurons and inputs of one MLP layer over a single shared neuron
// datapath, producing Moore enables and memory addresses.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int IN_W    = layer_seq_pkg::IN_W,
  parameter int NEU_W   = layer_seq_pkg::NEU_W,
  parameter int WADDR_W = layer_seq_pkg::WADDR_W
) (
  input logic               clk,
  input logic               rst,   // synchronous, active-low
  layer_sequencer_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IN_W-1:0]    n_inputs_q, n_inputs_d;
  logic [NEU_W-1:0]   n_neurons_q, n_neurons_d;
  // Running weight pointer: neurons are stored back to back, so the flat
  // address neuron_idx*n_inputs + in_idx is reached by counting MAC cycles.
  logic [WADDR_W-1:0] w_ptr_q, w_ptr_d;

  logic               in_clr, in_en, in_last;
  logic [IN_W-1:0]    in_idx;
  logic               neu_clr, neu_en, neu_last;
  logic [NEU_W-1:0]   neuron_idx;

  logic ready, done, acc_clear, load_input, acc_en, act_en, out_we;

  layer_seq_counter #(.W(IN_W)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (in_clr),
    .en    (in_en),
    .limit (n_inputs_q),
    .cnt   (in_idx),
    .last  (in_last)
  );

  layer_seq_counter #(.W(NEU_W)) u_neu_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (neu_clr),
    .en    (neu_en),
    .limit (n_neurons_q),
    .cnt   (neuron_idx),
    .last  (neu_last)
  );

  // Next-state, counter control and Moore output decode
  always_comb begin
    state_d     = state_q;
    n_inputs_d  = n_inputs_q;
    n_neurons_d = n_neurons_q;
    w_ptr_d     = w_ptr_q;
    in_clr      = 1'b0;
    in_en       = 1'b0;
    neu_clr     = 1'b0;
    neu_en      = 1'b0;
    ready       = 1'b0;
    done        = 1'b0;
    acc_clear   = 1'b0;
    load_input  = 1'b0;
    acc_en      = 1'b0;
    act_en      = 1'b0;
    out_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          n_inputs_d  = bus.n_inputs;
          n_neurons_d = bus.n_neurons;
          in_clr      = 1'b1;
          neu_clr     = 1'b1;
          w_ptr_d     = '0;
          state_d     = (bus.n_neurons == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clear = 1'b1;
        in_clr    = 1'b1;
        // A neuron with no inputs still produces its bias-only activation
        state_d   = (n_inputs_q != '0) ? S_FETCH : S_ACT;
      end
      S_FETCH: begin
        load_input = 1'b1;
        state_d    = S_MAC;
      end
      S_MAC: begin
        acc_en  = 1'b1;
        w_ptr_d = w_ptr_q + WADDR_W'(1);
        if (in_last) begin
          state_d = S_ACT;
        end else begin
          in_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ACT: begin
        act_en  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        out_we = 1'b1;
        if (neu_last) begin
          state_d = S_DONE;
        end else begin
          neu_en  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched layer size and weight pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_inputs_q  <= '0;
      n_neurons_q <= '0;
      w_ptr_q     <= '0;
    end else begin
      state_q     <= state_d;
      n_inputs_q  <= n_inputs_d;
      n_neurons_q <= n_neurons_d;
      w_ptr_q     <= w_ptr_d;
    end
  end

  assign bus.ready       = ready;
  assign bus.done        = done;
  assign bus.acc_clear   = acc_clear;
  assign bus.load_input  = load_input;
  assign bus.acc_en      = acc_en;
  assign bus.act_en      = act_en;
  assign bus.out_we      = out_we;
  assign bus.input_addr  = in_idx;
  assign bus.weight_addr = w_ptr_q;
  assign bus.out_addr    = neuron_idx;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer. Each layer request pushes the full
// expected stream of datapath events (kind, cycle, addresses); a negedge
// monitor pops and compares one entry per asserted enable / done pulse.
// Cycle numbering: cycle 0 is the cycle in which start is sampled in IDLE,
// so the first CLEAR is cycle 1 and done lands in cycle M*(2N+3)+1.
module tb_layer_sequencer;

  typedef enum int {EV_CLR, EV_LOAD, EV_MAC, EV_ACT, EV_WR, EV_DONE} ev_kind_e;

  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       a;   // input_addr for LOAD/MAC, out_addr for WR
    int       w;   // weight_addr for LOAD/MAC
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_sequencer_if bus ();

  layer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void push_ev(ev_kind_e k, int c, int a, int w, int cut);
    if (cut < 0 || c <= cut) sb.push_back('{kind: k, cyc: c, a: a, w: w});
  endfunction

  // Expected event stream of one layer accepted in cycle t0; events after
  // cycle 'cut' are dropped (cut < 0 keeps all).
  function automatic void push_layer(int t0, int n, int m, int cut);
    int b   = t0 + 1;
    int per = 2 * n + 3;
    for (int j = 0; j < m; j++) begin
      int s = b + j * per;
      push_ev(EV_CLR, s, 0, 0, cut);
      for (int i = 0; i < n; i++) begin
        push_ev(EV_LOAD, s + 1 + 2 * i, i, j * n + i, cut);
        push_ev(EV_MAC,  s + 2 + 2 * i, i, j * n + i, cut);
      end
      push_ev(EV_ACT, s + 1 + 2 * n, 0, 0, cut);
      push_ev(EV_WR,  s + 2 + 2 * n, j, 0, cut);
    end
    push_ev(EV_DONE, b + m * per, 0, 0, cut);
  endfunction

  task automatic expect_ev(input ev_kind_e k);
    ev_t e;
    if (sb.size() == 0) begin
      check({"extra_", k.name()}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({"kind_", k.name()}, k, e.kind);
    check({"cycle_", k.name()}, cyc, e.cyc);
    if (k == EV_LOAD || k == EV_MAC) begin
      check({"input_addr_", k.name()}, bus.input_addr, e.a);
      check({"weight_addr_", k.name()}, bus.weight_addr, e.w);
    end
    if (k == EV_WR) check("out_addr", bus.out_addr, e.a);
  endtask

  // Monitor: every enable / done pulse must match the next scoreboard entry
  always @(negedge clk) begin
    int n_en;
    n_en = int'(bus.acc_clear === 1'b1) + int'(bus.load_input === 1'b1) +
           int'(bus.acc_en === 1'b1) + int'(bus.act_en === 1'b1) + int'(bus.out_we === 1'b1);
    if (n_en > 1) check("one_enable", n_en, 1);
    if (bus.acc_clear === 1'b1)  expect_ev(EV_CLR);
    if (bus.load_input === 1'b1) expect_ev(EV_LOAD);
    if (bus.acc_en === 1'b1)     expect_ev(EV_MAC);
    if (bus.act_en === 1'b1)     expect_ev(EV_ACT);
    if (bus.out_we === 1'b1)     expect_ev(EV_WR);
    if (bus.done === 1'b1)       expect_ev(EV_DONE);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget && bus.ready !== 1'b1; i++) step();
    check("ready_wait", bus.ready, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_layer(input int n, input int m);
    int t0;
    wait_ready(50);
    t0 = cyc;
    bus.start     = 1'b1;
    bus.n_inputs  = 16'(n);
    bus.n_neurons = 8'(m);
    push_layer(t0, n, m, -1);
    step();
    // Inputs changing after acceptance must not matter
    bus.start     = 1'b0;
    bus.n_inputs  = 16'($urandom);
    bus.n_neurons = 8'($urandom);
    check("ready_low", bus.ready, 0);
    wait_drain(m * (2 * n + 3) + 20);
    step();
    check("ready_back", bus.ready, 1);
  endtask

  initial begin
    int t0, t1;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.n_inputs  = '0;
    bus.n_neurons = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Reset state
    check("rst_ready", bus.ready, 1);
    check("rst_enables", {bus.done, bus.acc_clear, bus.load_input, bus.acc_en,
                          bus.act_en, bus.out_we}, 0);
    check("rst_input_addr", bus.input_addr, 0);
    check("rst_weight_addr", bus.weight_addr, 0);
    check("rst_out_addr", bus.out_addr, 0);

    // Basic layer, bias-only neurons, empty layer
    run_layer(3, 2);
    run_layer(0, 2);
    run_layer(5, 0);

    // start held high, n_inputs changed mid-layer; re-accept takes new N
    wait_ready(50);
    t0 = cyc;
    t1 = t0 + 9;
    bus.start     = 1'b1;
    bus.n_inputs  = 16'd2;
    bus.n_neurons = 8'd1;
    push_layer(t0, 2, 1, -1);
    push_layer(t1, 3, 1, -1);
    repeat (3) step();
    bus.n_inputs = 16'd3;
    for (int i = 0; i < 40 && cyc < t1 + 1; i++) step();
    check("held_reaccept_cycle", cyc, t1 + 1);
    bus.start = 1'b0;
    wait_drain(40);
    step();
    check("held_ready_back", bus.ready, 1);

    // Reset during the first MAC of neuron 1 (N=4, M=3)
    wait_ready(50);
    t0 = cyc;
    bus.start     = 1'b1;
    bus.n_inputs  = 16'd4;
    bus.n_neurons = 8'd3;
    push_layer(t0, 4, 3, t0 + 14);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && cyc < t0 + 14; i++) step();
    check("abort_cycle", cyc, t0 + 14);
    rst = 1'b0;
    step();
    check("abort_ready", bus.ready, 1);
    check("abort_done", bus.done, 0);
    check("abort_out_we", bus.out_we, 0);
    check("abort_drain", sb.size(), 0);
    sb.delete();
    rst = 1'b1;
    run_layer(1, 1);

    // Input count beyond 8 bits: no truncation of the terminal compare
    run_layer(300, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
